// File: rtl/reset_sequencer.sv
// Reset sequencer for the FIFO-BIST subsystem.
// Holds the write, read and BIST domains in reset for a minimum width, confirms
// through synchronized feedback that the write and read domains entered and left
// reset, and releases them in order: write, then read, then BIST. A software/BIST
// request restarts the whole sequence. Every output comes straight from a flop.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,  // minimum assertion width, >= 2
  parameter int GAP_CYCLES  = 4,   // spacing after a confirmed release, >= 1
  parameter int ACK_TIMEOUT = 64   // feedback wait limit, >= 4
) (
  input  logic CLK,
  input  logic RST_IN,
  input  logic SW_RST_REQ,
  input  logic WR_RST_FB,
  input  logic RD_RST_FB,
  output logic WR_RST_N,
  output logic RD_RST_N,
  output logic BIST_RST_N,
  output logic RST_BUSY,
  output logic RST_DONE,
  output logic RST_ERR
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  // Terminal counts: each phase ends on the edge where the counter already
  // holds N-1, so the phase lasts exactly N edges.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_REL_WR  = 3'd2,
    ST_GAP_WR  = 3'd3,
    ST_REL_RD  = 3'd4,
    ST_GAP_RD  = 3'd5,
    ST_RUN     = 3'd6
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic wr_fb_meta, wr_fb_s;
  logic rd_fb_meta, rd_fb_s;

  logic fb_both_low;
  logic ack_expired;
  logic hold_done;
  logic gap_done;

  // Two-flop synchronizers: the feedback comes from other clock domains.
  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge value of its neighbour; a blocking '=' here would collapse the
  // two stages into one.
  always_ff @(posedge CLK or negedge RST_IN) begin
    if (!RST_IN) begin
      wr_fb_meta <= 1'b0;
      wr_fb_s    <= 1'b0;
      rd_fb_meta <= 1'b0;
      rd_fb_s    <= 1'b0;
    end else begin
      wr_fb_meta <= WR_RST_FB;
      wr_fb_s    <= wr_fb_meta;
      rd_fb_meta <= RD_RST_FB;
      rd_fb_s    <= rd_fb_meta;
    end
  end

  // Phase-end and feedback decodes; these only feed flops, never outputs.
  always_comb begin
    cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    fb_both_low = !wr_fb_s && !rd_fb_s;
    ack_expired = (cnt == ACK_LAST);
    hold_done   = (cnt == HOLD_LAST);
    gap_done    = (cnt == GAP_LAST);
  end

  // Sequencer FSM with registered reset outputs and status flags.
  always_ff @(posedge CLK or negedge RST_IN) begin
    if (!RST_IN) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      WR_RST_N   <= 1'b0;
      RD_RST_N   <= 1'b0;
      BIST_RST_N <= 1'b0;
      RST_BUSY   <= 1'b1;
      RST_DONE   <= 1'b0;
      RST_ERR    <= 1'b0;
    end else if (SW_RST_REQ) begin
      // A request overrides every state, including the GAP_RD exit edge,
      // and a held request keeps restarting the hold count.
      state      <= ST_ASSERT;
      cnt        <= '0;
      WR_RST_N   <= 1'b0;
      RD_RST_N   <= 1'b0;
      BIST_RST_N <= 1'b0;
      RST_BUSY   <= 1'b1;
      RST_DONE   <= 1'b0;
    end else begin
      RST_DONE <= 1'b0;
      case (state)
        ST_ASSERT: begin
          if (hold_done) begin
            state <= ST_WAIT_IN;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Both domains must be seen in reset before anything is released.
        ST_WAIT_IN: begin
          if (fb_both_low || ack_expired) begin
            state    <= ST_REL_WR;
            cnt      <= '0;
            WR_RST_N <= 1'b1;
            if (!fb_both_low) RST_ERR <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_REL_WR: begin
          if (wr_fb_s || ack_expired) begin
            state <= ST_GAP_WR;
            cnt   <= '0;
            if (!wr_fb_s) RST_ERR <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_GAP_WR: begin
          if (gap_done) begin
            state    <= ST_REL_RD;
            cnt      <= '0;
            RD_RST_N <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_REL_RD: begin
          if (rd_fb_s || ack_expired) begin
            state <= ST_GAP_RD;
            cnt   <= '0;
            if (!rd_fb_s) RST_ERR <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_GAP_RD: begin
          if (gap_done) begin
            state      <= ST_RUN;
            cnt        <= '0;
            BIST_RST_N <= 1'b1;
            RST_DONE   <= 1'b1;
            RST_BUSY   <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_RUN: begin
          cnt <= '0;
        end

        // NOTE: the unused encoding recovers into a full reset sequence rather
        // than being left undefined.
        default: begin
          state      <= ST_ASSERT;
          cnt        <= '0;
          WR_RST_N   <= 1'b0;
          RD_RST_N   <= 1'b0;
          BIST_RST_N <= 1'b0;
          RST_BUSY   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Feedback is modelled as a chain of CLK flops behind each reset request
// (tap 1 = a two-flop synchronizer). Predicted output rise events are queued
// when a sequence is started and popped by a monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int ACK  = 64;

  typedef enum int {EV_WR = 0, EV_RD = 1, EV_BIST = 2, EV_DONE = 3, EV_ERR = 4} evt_e;
  typedef struct {
    evt_e kind;
    int   at;
  } evt_t;

  logic CLK        = 1'b0;
  logic RST_IN     = 1'b0;
  logic SW_RST_REQ = 1'b0;
  logic WR_RST_FB, RD_RST_FB;
  logic WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE, RST_ERR;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .CLK       (CLK),
    .RST_IN    (RST_IN),
    .SW_RST_REQ(SW_RST_REQ),
    .WR_RST_FB (WR_RST_FB),
    .RD_RST_FB (RD_RST_FB),
    .WR_RST_N  (WR_RST_N),
    .RD_RST_N  (RD_RST_N),
    .BIST_RST_N(BIST_RST_N),
    .RST_BUSY  (RST_BUSY),
    .RST_DONE  (RST_DONE),
    .RST_ERR   (RST_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;   // number of rising edges so far
  int done_cnt = 0;
  bit exact    = 1'b1;

  evt_t sb[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Feedback model: flop chains behind the reset requests.
  logic [63:0] wr_pipe, rd_pipe;
  logic [5:0]  wr_dly   = 6'd1;
  logic [5:0]  rd_dly   = 6'd1;
  bit          wr_stuck = 1'b0;

  always @(posedge CLK or negedge RST_IN) begin
    if (!RST_IN) begin
      wr_pipe <= '0;
      rd_pipe <= '0;
    end else begin
      wr_pipe <= {wr_pipe[62:0], WR_RST_N};
      rd_pipe <= {rd_pipe[62:0], RD_RST_N};
    end
  end

  assign WR_RST_FB = wr_stuck ? 1'b0 : wr_pipe[wr_dly];
  assign RD_RST_FB = rd_pipe[rd_dly];

  // Predict the rise edges of one sequence started (hold count cleared) at edge x.
  // A feedback change reaches the FSM d+4 edges after the request edge:
  // pipe stage 0, d more stages, two DUT synchronizer flops, one edge to act.
  function automatic int push_seq(input int x, input int dw, input int dr,
                                  input bit stuck, input bit tail);
    int w, g, r, z, dmax;
    dmax = (dw > dr) ? dw : dr;
    w = x + HOLD + 1;                       // HOLD edges in ASSERT, one in WAIT_IN
    if (x + dmax + 4 > w) w = x + dmax + 4; // feedback still leaving the high state
    sb.push_back(evt_t'{EV_WR, w});
    if (stuck) begin
      g = w + ACK;
      sb.push_back(evt_t'{EV_ERR, g});
    end else begin
      g = w + dw + 4;
    end
    r = g + GAP;
    sb.push_back(evt_t'{EV_RD, r});
    z = r + dr + 4 + GAP;
    if (tail) begin
      sb.push_back(evt_t'{EV_BIST, z});
      sb.push_back(evt_t'{EV_DONE, z});
    end
    return z;
  endfunction

  // Monitor: detect rises (and DONE levels) and score them against the queue.
  logic p_wr = 1'b0, p_rd = 1'b0, p_bist = 1'b0, p_err = 1'b0;

  always @(negedge CLK) begin
    logic [4:0] hit;
    evt_t e;
    evt_e ek;
    hit = '0;
    if (RST_IN) begin
      hit[EV_WR]   = WR_RST_N && !p_wr;
      hit[EV_RD]   = RD_RST_N && !p_rd;
      hit[EV_BIST] = BIST_RST_N && !p_bist;
      hit[EV_DONE] = RST_DONE;
      hit[EV_ERR]  = RST_ERR && !p_err;
    end
    if (hit[EV_RD]) begin
      n_checks++;
      if (WR_RST_N !== 1'b1)
        $display("FAIL order_rd: RD_RST_N rose at edge %0d with WR_RST_N=%b, required 1", cyc, WR_RST_N);
      else n_pass++;
    end
    if (hit[EV_BIST]) begin
      n_checks++;
      if (RD_RST_N !== 1'b1)
        $display("FAIL order_bist: BIST_RST_N rose at edge %0d with RD_RST_N=%b, required 1", cyc, RD_RST_N);
      else n_pass++;
    end
    if (hit[EV_DONE]) begin
      done_cnt++;
      n_checks++;
      if (RST_BUSY !== 1'b0)
        $display("FAIL busy_at_done: RST_BUSY=%b at edge %0d, required 0", RST_BUSY, cyc);
      else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      if (hit[k] && (exact || k == int'(EV_DONE))) begin
        ek = evt_e'(k);
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_%s: seen at edge %0d, none pending", ek.name(), cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != ek || (exact && e.at != cyc))
            $display("FAIL event_%s: got %s at edge %0d, required %s at edge %0d",
                     e.kind.name(), ek.name(), cyc, e.kind.name(), e.at);
          else n_pass++;
        end
      end
    end
    p_wr   = WR_RST_N;
    p_rd   = RD_RST_N;
    p_bist = BIST_RST_N;
    p_err  = RST_ERR;
  end

  task automatic wait_sb_drain(input int budget, input string tag);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge CLK);
      i++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, next %s due edge %0d, now %0d",
               tag, sb.size(), budget, sb[0].kind.name(), sb[0].at, cyc);
      sb.delete();
    end else n_pass++;
  endtask

  task automatic release_rst(output int x);
    @(negedge CLK);
    RST_IN = 1'b1;
    x = cyc;
  endtask

  task automatic test_reset();
    RST_IN = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE, RST_ERR} !== 6'b000100)
      $display("FAIL reset_values: got %b, required 000100",
               {WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE, RST_ERR});
    else n_pass++;
  endtask

  task automatic test_nominal();
    int x;
    release_rst(x);
    void'(push_seq(x, 1, 1, 1'b0, 1'b1));
    wait_sb_drain(200, "nominal");
    repeat (5) @(negedge CLK);
    n_checks++;
    if ({BIST_RST_N, RST_BUSY, RST_ERR} !== 3'b100)
      $display("FAIL nominal_run: BIST/BUSY/ERR=%b, required 100", {BIST_RST_N, RST_BUSY, RST_ERR});
    else n_pass++;
  endtask

  task automatic test_fb_stuck();
    int x;
    @(negedge CLK);
    RST_IN   = 1'b0;
    wr_stuck = 1'b1;
    repeat (2) @(negedge CLK);
    release_rst(x);
    void'(push_seq(x, 1, 1, 1'b1, 1'b1));
    wait_sb_drain(300, "fb_stuck");
    repeat (20) @(negedge CLK);
    n_checks++;
    if ({RST_ERR, RST_BUSY, BIST_RST_N} !== 3'b101)
      $display("FAIL stuck_sticky: ERR/BUSY/BIST=%b, required 101", {RST_ERR, RST_BUSY, BIST_RST_N});
    else n_pass++;
  endtask

  task automatic test_rst_mid_rel_rd();
    int x;
    wr_stuck = 1'b0;
    repeat (3) @(negedge CLK);
    SW_RST_REQ = 1'b1;
    x = cyc + 1;
    void'(push_seq(x, 1, 1, 1'b0, 1'b0));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    wait_sb_drain(200, "mid_rd_lead_in");
    @(negedge CLK);
    n_checks++;
    if ({RD_RST_N, RST_ERR, RST_BUSY} !== 3'b111)
      $display("FAIL mid_rd_pre: RD/ERR/BUSY=%b, required 111", {RD_RST_N, RST_ERR, RST_BUSY});
    else n_pass++;
    #2 RST_IN = 1'b0;
    #1;
    n_checks++;
    if ({WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE, RST_ERR} !== 6'b000100)
      $display("FAIL async_reset: got %b, required 000100",
               {WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE, RST_ERR});
    else n_pass++;
    repeat (2) @(negedge CLK);
    release_rst(x);
    void'(push_seq(x, 1, 1, 1'b0, 1'b1));
    wait_sb_drain(200, "restart");
    n_checks++;
    if (RST_ERR !== 1'b0)
      $display("FAIL restart_err: RST_ERR=%b, required 0", RST_ERR);
    else n_pass++;
  endtask

  task automatic test_sw_req_run();
    int x;
    repeat (4) @(negedge CLK);
    SW_RST_REQ = 1'b1;
    x = cyc + 1;
    void'(push_seq(x, 1, 1, 1'b0, 1'b1));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    n_checks++;
    if ({WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE} !== 5'b00010)
      $display("FAIL sw_entry: WR/RD/BIST/BUSY/DONE=%b, required 00010",
               {WR_RST_N, RD_RST_N, BIST_RST_N, RST_BUSY, RST_DONE});
    else n_pass++;
    wait_sb_drain(200, "sw_run");
    repeat (10) @(negedge CLK);
    n_checks++;
    if ({RST_BUSY, BIST_RST_N} !== 2'b01)
      $display("FAIL sw_run_end: BUSY/BIST=%b, required 01", {RST_BUSY, BIST_RST_N});
    else n_pass++;
  endtask

  task automatic test_sw_req_gap_rd();
    int x, z;
    // Request sampled exactly on the GAP_RD exit edge.
    @(negedge CLK);
    SW_RST_REQ = 1'b1;
    x = cyc + 1;
    z = push_seq(x, 1, 1, 1'b0, 1'b0);
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    while (cyc < z - 1) @(negedge CLK);
    SW_RST_REQ = 1'b1;
    void'(push_seq(z, 1, 1, 1'b0, 1'b1));
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    n_checks++;
    if ({WR_RST_N, BIST_RST_N, RST_BUSY, RST_DONE} !== 4'b0010)
      $display("FAIL gap_exit_req: WR/BIST/BUSY/DONE=%b at edge %0d, required 0010",
               {WR_RST_N, BIST_RST_N, RST_BUSY, RST_DONE}, cyc);
    else n_pass++;
    wait_sb_drain(200, "gap_exit");
    // Request held across all of GAP_RD.
    @(negedge CLK);
    SW_RST_REQ = 1'b1;
    x = cyc + 1;
    z = push_seq(x, 1, 1, 1'b0, 1'b0);
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    while (cyc < z - GAP) @(negedge CLK);
    SW_RST_REQ = 1'b1;
    while (cyc < z) @(negedge CLK);
    SW_RST_REQ = 1'b0;
    void'(push_seq(z, 1, 1, 1'b0, 1'b1));
    wait_sb_drain(200, "gap_held");
    n_checks++;
    if ({RST_BUSY, BIST_RST_N} !== 2'b01)
      $display("FAIL gap_held_end: BUSY/BIST=%b, required 01", {RST_BUSY, BIST_RST_N});
    else n_pass++;
  endtask

  task automatic test_random();
    exact    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      wr_dly = 6'($urandom_range(60, 0));
      rd_dly = 6'($urandom_range(60, 0));
      sb.push_back(evt_t'{EV_DONE, 0});
      @(negedge CLK);
      SW_RST_REQ = 1'b1;
      @(negedge CLK);
      SW_RST_REQ = 1'b0;
      wait_sb_drain(400, "random");
      repeat ($urandom_range(3, 0)) @(negedge CLK);
    end
    repeat (5) @(negedge CLK);
    n_checks++;
    if (done_cnt != 200)
      $display("FAIL random_done_count: got %0d, required 200", done_cnt);
    else n_pass++;
    n_checks++;
    if (RST_ERR !== 1'b0)
      $display("FAIL random_err: RST_ERR=%b, required 0", RST_ERR);
    else n_pass++;
    exact  = 1'b1;
    wr_dly = 6'd1;
    rd_dly = 6'd1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fb_stuck();
    test_rst_mid_rel_rd();
    test_sw_req_run();
    test_sw_req_gap_rd();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
